alarm_timekeeper: RTL and testbench

ALARM_TIMEKEEPER -- requirements
Module: alarm_timekeeper

---
 rtl/alarm_pkg.sv | 29 ++
 rtl/bcd_mod_counter.sv | 45 ++++
 rtl/alarm_timekeeper.sv | 148 ++++++++++++++
 tb/tb_alarm_timekeeper.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock: FSM encoding, BCD limits and reset alarm.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } alarm_state_t;

  localparam int MAX_SEC  = 59;
  localparam int MAX_MIN  = 59;
  localparam int MAX_HOUR = 23;

  localparam int SEC_MOD  = MAX_SEC + 1;
  localparam int MIN_MOD  = MAX_MIN + 1;
  localparam int HOUR_MOD = MAX_HOUR + 1;

  localparam logic [7:0] ALARM_RST_HH = 8'h06;
  localparam logic [7:0] ALARM_RST_MM = 8'h00;

  // Convert a small binary value (0..99) to packed BCD.
  function automatic logic [7:0] bin_to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps at MOD-1 and flags the wrap as carry.
module bcd_mod_counter
  import alarm_pkg::*;
#(
  parameter int         MOD     = 60,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  localparam logic [7:0] MAX_BCD = bin_to_bcd(MOD - 1);

  logic [7:0] value_reg;
  logic       step;
  logic       at_max;

  assign step   = en & inc;
  assign at_max = (value_reg == MAX_BCD);
  assign carry  = step & at_max;
  assign value  = value_reg;

  // Advance the units digit, rolling into tens at 9 and back to 00 at the modulus.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= RST_VAL;
    end else if (clr) begin
      value_reg <= 8'h00;
    end else if (step) begin
      if (at_max) begin
        value_reg <= 8'h00;
      end else if (value_reg[3:0] == 4'd9) begin
        value_reg <= {value_reg[7:4] + 4'd1, 4'd0};
      end else begin
        value_reg <= {value_reg[7:4], value_reg[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/alarm_timekeeper.sv
// BCD time-of-day clock with settable alarm, auto-stop ringing and snooze.
module alarm_timekeeper
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [7:0] alarm_hh,
  output logic [7:0] alarm_mm,
  output logic       ring
);

  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SEC);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SEC);

  logic count_mode;
  logic alarm_edit;
  logic ss_carry;
  logic mm_carry;
  logic mm_inc;
  logic hh_inc;
  logic unused_hh_carry;
  logic unused_amm_carry;
  logic unused_ahh_carry;
  logic unused_carries;

  // Time counts on ticks unless being edited; editing steps minutes/hours
  // directly and never lets a minute wrap ripple into the hour.
  assign count_mode = ~set_time;
  assign alarm_edit = set_alarm & ~set_time;
  assign mm_inc     = set_time ? inc_min  : ss_carry;
  assign hh_inc     = set_time ? inc_hour : mm_carry;
  assign unused_carries = unused_hh_carry ^ unused_amm_carry ^ unused_ahh_carry;

  bcd_mod_counter #(.MOD(SEC_MOD), .RST_VAL(8'h00)) u_ss (
    .clk(clk), .rst(rst), .clr(set_time), .en(count_mode), .inc(tick),
    .value(ss), .carry(ss_carry)
  );

  bcd_mod_counter #(.MOD(MIN_MOD), .RST_VAL(8'h00)) u_mm (
    .clk(clk), .rst(rst), .clr(1'b0), .en(1'b1), .inc(mm_inc),
    .value(mm), .carry(mm_carry)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD), .RST_VAL(8'h00)) u_hh (
    .clk(clk), .rst(rst), .clr(1'b0), .en(1'b1), .inc(hh_inc),
    .value(hh), .carry(unused_hh_carry)
  );

  bcd_mod_counter #(.MOD(MIN_MOD), .RST_VAL(ALARM_RST_MM)) u_alarm_mm (
    .clk(clk), .rst(rst), .clr(1'b0), .en(alarm_edit), .inc(inc_min),
    .value(alarm_mm), .carry(unused_amm_carry)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD), .RST_VAL(ALARM_RST_HH)) u_alarm_hh (
    .clk(clk), .rst(rst), .clr(1'b0), .en(alarm_edit), .inc(inc_hour),
    .value(alarm_hh), .carry(unused_ahh_carry)
  );

  alarm_state_t  state_reg;
  logic [CW-1:0] cnt_reg;
  logic          tick_seen_reg;
  logic          ring_reg;
  logic          alarm_hit;

  // The time registered on the previous edge came from a counting tick and
  // equals the alarm setting; checking one edge later gives the ring latency.
  assign alarm_hit = tick_seen_reg & alarm_en & ~set_time &
                     (hh == alarm_hh) & (mm == alarm_mm) & (ss == 8'h00);

  assign ring = ring_reg;

  // Alarm FSM with ring/snooze second counter; ring is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      tick_seen_reg <= 1'b0;
      ring_reg      <= 1'b0;
    end else begin
      tick_seen_reg <= tick & ~set_time;
      case (state_reg)
        ST_IDLE: begin
          if (alarm_hit) begin
            state_reg <= ST_RINGING;
            cnt_reg   <= RING_LOAD;
            ring_reg  <= 1'b1;
          end
        end
        ST_RINGING: begin
          if (stop || !alarm_en) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ring_reg  <= 1'b0;
          end else if (snooze) begin
            state_reg <= ST_SNOOZED;
            cnt_reg   <= SNOOZE_LOAD;
            ring_reg  <= 1'b0;
          end else if (tick) begin
            if (cnt_reg <= CW'(1)) begin
              state_reg <= ST_IDLE;
              cnt_reg   <= '0;
              ring_reg  <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg - CW'(1);
            end
          end
        end
        ST_SNOOZED: begin
          if (stop || !alarm_en) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ring_reg  <= 1'b0;
          end else if (tick) begin
            if (cnt_reg <= CW'(1)) begin
              state_reg <= ST_RINGING;
              cnt_reg   <= RING_LOAD;
              ring_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - CW'(1);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          ring_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Self-checking bench for alarm_timekeeper: directed scenarios plus randomized
// stimulus compared against a seconds-of-day reference model.
module tb_alarm_timekeeper;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;
  localparam int M_IDLE     = 0;
  localparam int M_RING     = 1;
  localparam int M_SNOOZE   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       tick = 1'b0, set_time = 1'b0, set_alarm = 1'b0;
  logic       inc_hour = 1'b0, inc_min = 1'b0, alarm_en = 1'b0;
  logic       snooze = 1'b0, stop = 1'b0;
  logic [7:0] hh, mm, ss, alarm_hh, alarm_mm;
  logic       ring;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time as seconds of day, alarm as hour/minute integers.
  int m_t = 0, m_ah = 6, m_am = 0, m_state = M_IDLE, m_cnt = 0;
  bit m_pending = 1'b0;

  alarm_timekeeper #(.RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)) dut (
    .clk(clk), .rst(rst), .tick(tick), .set_time(set_time), .set_alarm(set_alarm),
    .inc_hour(inc_hour), .inc_min(inc_min), .alarm_en(alarm_en),
    .snooze(snooze), .stop(stop),
    .hh(hh), .mm(mm), .ss(ss), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .ring(ring)
  );

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic model_update();
    int h, m;
    bit match;
    if (rst) begin
      m_t = 0; m_ah = 6; m_am = 0; m_state = M_IDLE; m_cnt = 0; m_pending = 1'b0;
      return;
    end
    match = m_pending && alarm_en && !set_time && (m_t == m_ah * 3600 + m_am * 60);
    case (m_state)
      M_IDLE: if (match) begin m_state = M_RING; m_cnt = RING_SEC; end
      M_RING: begin
        if (stop || !alarm_en) m_state = M_IDLE;
        else if (snooze) begin m_state = M_SNOOZE; m_cnt = SNOOZE_SEC; end
        else if (tick) begin
          m_cnt = m_cnt - 1;
          if (m_cnt <= 0) m_state = M_IDLE;
        end
      end
      default: begin
        if (stop || !alarm_en) m_state = M_IDLE;
        else if (tick) begin
          m_cnt = m_cnt - 1;
          if (m_cnt <= 0) begin m_state = M_RING; m_cnt = RING_SEC; end
        end
      end
    endcase
    if (set_time) begin
      h = m_t / 3600;
      m = (m_t / 60) % 60;
      if (inc_min)  m = (m + 1) % 60;
      if (inc_hour) h = (h + 1) % 24;
      m_t = h * 3600 + m * 60;
    end else if (tick) begin
      m_t = (m_t + 1) % 86400;
    end
    if (set_alarm && !set_time) begin
      if (inc_min)  m_am = (m_am + 1) % 60;
      if (inc_hour) m_ah = (m_ah + 1) % 24;
    end
    m_pending = tick && !set_time;
  endtask

  // One clock: DUT and model see the same inputs, outputs settle by #1, pulses drop.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    tick = 1'b0; inc_hour = 1'b0; inc_min = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  task automatic tick_cycle();
    tick = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // Alarm 00:01 armed, time run to 00:01:00, ringing one clk later.
  task automatic go_ringing();
    do_reset();
    alarm_en = 1'b1;
    set_alarm = 1'b1;
    for (int i = 0; i < 18; i++) begin inc_hour = 1'b1; cycle(); end
    inc_min = 1'b1; cycle();
    set_alarm = 1'b0;
    for (int i = 0; i < 60; i++) tick_cycle();
  endtask

  task automatic test_reset();
    set_time = 1'b0; set_alarm = 1'b0; alarm_en = 1'b0;
    do_reset();
    n_tests++; if (hh !== 8'h00) begin n_fail++; $display("FAIL reset_hh got %h exp 00", hh); end
    n_tests++; if (mm !== 8'h00) begin n_fail++; $display("FAIL reset_mm got %h exp 00", mm); end
    n_tests++; if (ss !== 8'h00) begin n_fail++; $display("FAIL reset_ss got %h exp 00", ss); end
    n_tests++; if (alarm_hh !== 8'h06) begin n_fail++; $display("FAIL reset_alarm_hh got %h exp 06", alarm_hh); end
    n_tests++; if (alarm_mm !== 8'h00) begin n_fail++; $display("FAIL reset_alarm_mm got %h exp 00", alarm_mm); end
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL reset_ring got %b exp 0", ring); end
  endtask

  task automatic test_rollover();
    do_reset();
    set_time = 1'b1;
    for (int i = 0; i < 59; i++) begin inc_min = 1'b1; inc_hour = (i < 23); cycle(); end
    set_time = 1'b0;
    for (int i = 0; i < 58; i++) tick_cycle();
    n_tests++; if ({hh, mm, ss} !== 24'h235958) begin n_fail++; $display("FAIL load_235958 got %h exp 235958", {hh, mm, ss}); end
    tick_cycle();
    n_tests++; if ({hh, mm, ss} !== 24'h235959) begin n_fail++; $display("FAIL tick_235959 got %h exp 235959", {hh, mm, ss}); end
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL ring_235959 got %b exp 0", ring); end
    tick_cycle();
    n_tests++; if ({hh, mm, ss} !== 24'h000000) begin n_fail++; $display("FAIL wrap_000000 got %h exp 000000", {hh, mm, ss}); end
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL ring_wrap got %b exp 0", ring); end
  endtask

  task automatic test_alarm_trigger();
    do_reset();
    alarm_en = 1'b1;
    set_alarm = 1'b1;
    for (int i = 0; i < 18; i++) begin inc_hour = 1'b1; cycle(); end
    inc_min = 1'b1; cycle();
    set_alarm = 1'b0;
    n_tests++; if ({alarm_hh, alarm_mm} !== 16'h0001) begin n_fail++; $display("FAIL alarm_set got %h exp 0001", {alarm_hh, alarm_mm}); end
    for (int i = 0; i < 59; i++) tick_cycle();
    n_tests++; if ({hh, mm, ss} !== 24'h000059) begin n_fail++; $display("FAIL pre_match got %h exp 000059", {hh, mm, ss}); end
    tick = 1'b1; cycle();
    n_tests++; if ({hh, mm, ss} !== 24'h000100) begin n_fail++; $display("FAIL match_time got %h exp 000100", {hh, mm, ss}); end
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL ring_same_edge got %b exp 0", ring); end
    cycle();
    n_tests++; if (ring !== 1'b1) begin n_fail++; $display("FAIL ring_next_clk got %b exp 1", ring); end
  endtask

  task automatic test_auto_stop();
    for (int i = 0; i < 59; i++) tick_cycle();
    n_tests++; if (ring !== 1'b1) begin n_fail++; $display("FAIL ring_after_59 got %b exp 1", ring); end
    tick = 1'b1; cycle();
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL ring_after_60 got %b exp 0", ring); end
    for (int i = 0; i < 5; i++) tick_cycle();
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL idle_stays got %b exp 0", ring); end
  endtask

  task automatic test_snooze();
    go_ringing();
    n_tests++; if (ring !== 1'b1) begin n_fail++; $display("FAIL snooze_pre_ring got %b exp 1", ring); end
    snooze = 1'b1; cycle();
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL snooze_drop got %b exp 0", ring); end
    for (int i = 0; i < 299; i++) begin
      if (i == 100) snooze = 1'b1;
      tick_cycle();
    end
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL snooze_299 got %b exp 0", ring); end
    tick = 1'b1; cycle();
    n_tests++; if (ring !== 1'b1) begin n_fail++; $display("FAIL snooze_300 got %b exp 1", ring); end
    stop = 1'b1; cycle();
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL stop_drop got %b exp 0", ring); end
  endtask

  task automatic test_set_time();
    do_reset();
    set_time = 1'b1;
    for (int i = 0; i < 58; i++) begin inc_min = 1'b1; cycle(); end
    n_tests++; if ({hh, mm} !== 16'h0058) begin n_fail++; $display("FAIL set_0058 got %h exp 0058", {hh, mm}); end
    for (int i = 0; i < 5; i++) begin inc_min = 1'b1; tick = 1'b1; cycle(); tick = 1'b1; cycle(); end
    n_tests++; if (mm !== 8'h03) begin n_fail++; $display("FAIL set_mm got %h exp 03", mm); end
    n_tests++; if (hh !== 8'h00) begin n_fail++; $display("FAIL set_hh_nocarry got %h exp 00", hh); end
    n_tests++; if (ss !== 8'h00) begin n_fail++; $display("FAIL set_ss_held got %h exp 00", ss); end
    inc_min = 1'b1; inc_hour = 1'b1; set_alarm = 1'b1; cycle();
    set_alarm = 1'b0;
    n_tests++; if ({hh, mm, alarm_hh, alarm_mm} !== 32'h01040600) begin n_fail++; $display("FAIL set_both got %h exp 01040600", {hh, mm, alarm_hh, alarm_mm}); end
    set_time = 1'b0;
  endtask

  task automatic test_reset_mid_ring();
    go_ringing();
    n_tests++; if (ring !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ring got %b exp 1", ring); end
    rst = 1'b1; tick = 1'b1; cycle();
    rst = 1'b0;
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL rst_ring got %b exp 0", ring); end
    n_tests++; if ({hh, mm, ss} !== 24'h000000) begin n_fail++; $display("FAIL rst_time got %h exp 000000", {hh, mm, ss}); end
    n_tests++; if ({alarm_hh, alarm_mm} !== 16'h0600) begin n_fail++; $display("FAIL rst_alarm got %h exp 0600", {alarm_hh, alarm_mm}); end
  endtask

  task automatic test_random();
    logic [7:0] e_hh, e_mm, e_ss, e_ahh, e_amm;
    logic       e_ring;
    go_ringing();
    for (int i = 0; i < 6000; i++) begin
      tick     = ($urandom_range(0, 2) == 0);
      inc_min  = ($urandom_range(0, 7) == 0);
      inc_hour = ($urandom_range(0, 7) == 0);
      snooze   = ($urandom_range(0, 39) == 0);
      stop     = ($urandom_range(0, 299) == 0);
      rst      = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 119) == 0) set_time  = ~set_time;
      if ($urandom_range(0, 59) == 0)  set_alarm = ~set_alarm;
      if ($urandom_range(0, 399) == 0) alarm_en  = ~alarm_en;
      // Occasionally drop the alarm onto the next minute so matches recur.
      if (i % 700 == 350 && m_state == M_IDLE) begin
        set_time = 1'b0; set_alarm = 1'b0; alarm_en = 1'b1;
      end
      cycle();
      rst = 1'b0;
      e_hh = bcd(m_t / 3600); e_mm = bcd((m_t / 60) % 60); e_ss = bcd(m_t % 60);
      e_ahh = bcd(m_ah); e_amm = bcd(m_am); e_ring = (m_state == M_RING);
      n_tests++;
      if ({hh, mm, ss, alarm_hh, alarm_mm, ring} !== {e_hh, e_mm, e_ss, e_ahh, e_amm, e_ring}) begin
        n_fail++;
        $display("FAIL random_cycle%0d got %h:%h:%h al %h:%h ring %b exp %h:%h:%h al %h:%h ring %b",
                 i, hh, mm, ss, alarm_hh, alarm_mm, ring, e_hh, e_mm, e_ss, e_ahh, e_amm, e_ring);
      end
    end
    set_time = 1'b0; set_alarm = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_alarm_trigger();
    test_auto_stop();
    test_snooze();
    test_set_time();
    test_reset_mid_ring();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
